// File: rtl/cache_parameters.sv
// rtl/cache_parameters.sv - shared cache/memory widths, request/response structs and controller state enum
package cache_parameters;

  localparam int ADDR_WIDTH = 12;
  localparam int WORD_WIDTH = 32;
  localparam int BLOCK_SIZE = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction

  localparam int OFFSET_WIDTH = clog2(BLOCK_SIZE);
  localparam int BLOCK_WIDTH  = BLOCK_SIZE * WORD_WIDTH;

  typedef enum logic [1:0] {
    m_idle,
    m_busy,
    m_resp,
    m_release
  } mem_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   cs;
    logic                   rw;
    logic [BLOCK_WIDTH-1:0] wdata;
  } memory_request_t;

  typedef struct packed {
    logic                   ack;
    logic                   busy;
    logic [BLOCK_WIDTH-1:0] rdata;
  } memory_response_t;

endpackage

// File: rtl/block_mem_ctrl_ram.sv
// rtl/block_mem_ctrl_ram.sv - banked block RAM: one word bank per block slot, full-block write, registered full-block read, no reset
module block_mem_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32,
  parameter int BLOCK_SIZE = 2
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] wdata,
  output logic [BLOCK_SIZE*WORD_WIDTH-1:0] rdata
);

  localparam int OFFSET_W = cache_parameters::clog2(BLOCK_SIZE);
  localparam int ROW_W    = ADDR_WIDTH - OFFSET_W;

  // Word base+i of an aligned block lives in bank i at row base>>OFFSET_W.
  logic [ROW_W-1:0] row;
  assign row = ROW_W'(addr >> OFFSET_W);

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_bank
    logic [WORD_WIDTH-1:0] mem [2**ROW_W];
    logic [WORD_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (we) mem[row] <= wdata[i*WORD_WIDTH +: WORD_WIDTH];
      if (re) rd_q <= mem[row];
    end

    assign rdata[i*WORD_WIDTH +: WORD_WIDTH] = rd_q;
  end

endmodule

// File: rtl/block_mem_ctrl.sv
// rtl/block_mem_ctrl.sv - fixed-latency block memory controller behind the cache
// Optional access counters (rd_count/wr_count) are built when BLOCK_MEM_STATS_EN is defined.
module block_mem_ctrl #(
  parameter int ADDR_WIDTH = cache_parameters::ADDR_WIDTH,
  parameter int WORD_WIDTH = cache_parameters::WORD_WIDTH,
  parameter int BLOCK_SIZE = cache_parameters::BLOCK_SIZE,
  parameter int LATENCY    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic                             mem_cs,
  input  logic                             mem_rw,
  input  logic [BLOCK_SIZE*WORD_WIDTH-1:0] mem_wdata,
  output logic                             mem_ack,
  output logic [BLOCK_SIZE*WORD_WIDTH-1:0] mem_rdata,
  output logic                             mem_busy
`ifdef BLOCK_MEM_STATS_EN
  ,
  output logic [15:0]                      rd_count,
  output logic [15:0]                      wr_count
`endif
);

  import cache_parameters::*;

  localparam int BLOCK_W = BLOCK_SIZE * WORD_WIDTH;
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);

  if (LATENCY < 1) begin : g_latency_check
    $error("block_mem_ctrl: LATENCY must be at least 1");
  end
  if (ADDR_WIDTH != cache_parameters::ADDR_WIDTH || WORD_WIDTH != cache_parameters::WORD_WIDTH ||
      BLOCK_SIZE != cache_parameters::BLOCK_SIZE) begin : g_width_check
    $error("block_mem_ctrl: widths must match the cache_parameters package");
  end

  memory_request_t  req;
  memory_response_t resp;

  assign req.addr  = mem_addr;
  assign req.cs    = mem_cs;
  assign req.rw    = mem_rw;
  assign req.wdata = mem_wdata;

  assign mem_ack   = resp.ack;
  assign mem_busy  = resp.busy;
  assign mem_rdata = resp.rdata;

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  rw_q, rw_d;
  logic [BLOCK_W-1:0]    wdata_q, wdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ram_we, ram_re;
  logic [BLOCK_W-1:0]    ram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    case (state_q)
      m_idle: begin
        if (req.cs) begin
          base_d  = req.addr & ALIGN_MASK;
          rw_d    = req.rw;
          wdata_d = req.wdata;
          cnt_d   = CNT_LOAD;
          state_d = m_busy;
        end
      end
      m_busy: begin
        if (cnt_q == '0) begin
          ram_we  = rw_q;
          ram_re  = !rw_q;
          state_d = m_resp;
          if (!rw_q) rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      m_resp:    state_d = m_release;
      // Hold here until the cache drops cs so a sticky request is not served twice.
      m_release: if (!req.cs) state_d = m_idle;
      default:   state_d = m_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= m_idle;
      cnt_q    <= '0;
      base_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  block_mem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (base_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // The RAM read register has no reset, so the visible block is gated until a read lands.
  assign resp.ack   = (state_q == m_resp);
  assign resp.busy  = (state_q != m_idle);
  assign resp.rdata = rvalid_q ? ram_rdata : '0;

`ifdef BLOCK_MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == m_resp) begin
      if (rw_q) begin
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_block_mem_ctrl.sv
// tb/tb_block_mem_ctrl.sv - self-checking bench for block_mem_ctrl (LATENCY 4 and LATENCY 1 instances)
module tb_block_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, cs0, rw0, ack0, busy0;
  logic [11:0] addr0;
  logic [63:0] wdata0, rdata0;
  logic        rst1, cs1, rw1, ack1, busy1;
  logic [11:0] addr1;
  logic [63:0] wdata1, rdata1;
`ifdef BLOCK_MEM_STATS_EN
  logic [15:0] rdc0, wrc0, rdc1, wrc1;
`endif

  block_mem_ctrl #(.LATENCY(4)) dut0 (
    .clk(clk), .rst_n(rst0), .mem_addr(addr0), .mem_cs(cs0), .mem_rw(rw0),
    .mem_wdata(wdata0), .mem_ack(ack0), .mem_rdata(rdata0), .mem_busy(busy0)
`ifdef BLOCK_MEM_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0)
`endif
  );

  block_mem_ctrl #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst1), .mem_addr(addr1), .mem_cs(cs1), .mem_rw(rw1),
    .mem_wdata(wdata1), .mem_ack(ack1), .mem_rdata(rdata1), .mem_busy(busy1)
`ifdef BLOCK_MEM_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] model [int];
  logic [63:0] last_rd [2];
  int          n_rd [2];
  int          n_wr [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ack(input int which);
    return (which != 0) ? ack1 : ack0;
  endfunction
  function automatic logic f_busy(input int which);
    return (which != 0) ? busy1 : busy0;
  endfunction
  function automatic logic [63:0] f_rdata(input int which);
    return (which != 0) ? rdata1 : rdata0;
  endfunction

  task automatic set_in(input int which, input logic cs, input logic [11:0] a, input logic rw,
                        input logic [63:0] wd);
    if (which == 0) begin
      cs0 = cs; addr0 = a; rw0 = rw; wdata0 = wd;
    end else begin
      cs1 = cs; addr1 = a; rw1 = rw; wdata1 = wd;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic txn(input int which, input logic [11:0] a, input logic rw, input logic [63:0] wd,
                     input int hold, input bit perturb);
    int lat, acks, rel, key, exp_lat;
    logic [63:0] exp;
    key     = which * 4096 + int'(a >> 1);
    exp_lat = (which != 0) ? 1 : 4;
    exp     = rw ? last_rd[which] : model[key];
    set_in(which, 1'b1, a, rw, wd);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_accept", 64'(f_busy(which)), 64'd1);
    if (perturb) set_in(which, 1'b1, a ^ 12'h060, ~rw, ~wd);
    lat = 0;
    while (!f_ack(which) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ack_latency", 64'(lat), 64'(exp_lat));
    check(rw ? "rdata_held_on_write" : "read_data", f_rdata(which), exp);
    if (rw) begin
      model[key] = wd;
      n_wr[which]++;
    end else begin
      last_rd[which] = exp;
      n_rd[which]++;
    end
    acks = 1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (f_ack(which)) acks++;
    end
    set_in(which, 1'b0, 'x, 'x, 'x);
    rel = 0;
    do begin
      @(negedge clk);
      rel++;
      if (f_ack(which)) acks++;
    end while (f_busy(which) && rel < 40);
    check("single_ack", 64'(acks), 64'd1);
    check("release_to_idle", 64'(rel), (hold == 0) ? 64'd2 : 64'd1);
  endtask

  initial begin
    int acks;
    logic [11:0] a;
    rst0 = 1'b0; rst1 = 1'b0;
    set_in(0, 1'b0, '0, 1'b0, '0);
    set_in(1, 1'b0, '0, 1'b0, '0);
    last_rd[0] = '0; last_rd[1] = '0;
    n_rd[0] = 0; n_rd[1] = 0; n_wr[0] = 0; n_wr[1] = 0;
    repeat (3) @(negedge clk);
    check("reset_ack", 64'(ack0), 64'd0);
    check("reset_busy", 64'(busy0), 64'd0);
    check("reset_rdata", rdata0, 64'd0);
    check("reset_busy_l1", 64'(busy1), 64'd0);
    rst0 = 1'b1; rst1 = 1'b1;

    // Write then read with offset bit set.
    txn(0, 12'h010, 1'b1, 64'h12345678_DEADBEEF, 0, 1'b0);
    txn(0, 12'h011, 1'b0, 64'd0, 0, 1'b0);
    check("write_read_words", rdata0, 64'h12345678_DEADBEEF);

    // Sticky cs held three cycles past ack.
    txn(0, 12'h010, 1'b0, 64'd0, 3, 1'b0);

    // Idle with X on unused inputs.
    set_in(0, 1'b0, 'x, 'x, 'x);
    repeat (3) @(negedge clk);
    check("idle_x_busy", 64'(busy0), 64'd0);
    check("idle_x_ack", 64'(ack0), 64'd0);
    check("idle_x_rdata", rdata0, last_rd[0]);

    // Inputs changed during BUSY must be ignored.
    txn(0, 12'h020, 1'b1, 64'hA5A5_0020_5A5A_0020, 0, 1'b0);
    txn(0, 12'h040, 1'b1, 64'hC3C3_0040_3C3C_0040, 0, 1'b0);
    txn(0, 12'h020, 1'b0, 64'h1111_2222_3333_4444, 0, 1'b1);
    txn(0, 12'h040, 1'b0, 64'd0, 0, 1'b0);

    // Reset two cycles into a write aborts it.
    txn(0, 12'h030, 1'b1, 64'hFEED_F00D_0BAD_CAFE, 0, 1'b0);
    txn(0, 12'h030, 1'b0, 64'd0, 0, 1'b0);
    set_in(0, 1'b1, 12'h030, 1'b1, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_rdata", rdata0, 64'd0);
    check("abort_ack", 64'(ack0), 64'd0);
    last_rd[0] = '0; n_rd[0] = 0; n_wr[0] = 0;
    set_in(0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst0 = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0) acks++;
    end
    check("abort_no_ack", 64'(acks), 64'd0);
    txn(0, 12'h030, 1'b0, 64'd0, 0, 1'b0);
    check("abort_keeps_old", rdata0, 64'hFEED_F00D_0BAD_CAFE);

    // Randomized traffic over eight blocks.
    for (int i = 0; i < 8; i++)
      txn(0, 12'h100 + 12'(2 * i), 1'b1, {$urandom, $urandom}, 0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      a = 12'h100 + 12'(2 * $urandom_range(0, 7)) + 12'($urandom_range(0, 1));
      txn(0, a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 2), 1'b0);
    end

    // LATENCY = 1, back-to-back with a single idle cycle between requests.
    txn(1, 12'h200, 1'b1, 64'h0000_0002_0000_0001, 0, 1'b0);
    txn(1, 12'h202, 1'b1, 64'h0000_0004_0000_0003, 0, 1'b0);
    txn(1, 12'h200, 1'b0, 64'd0, 0, 1'b0);
    txn(1, 12'h203, 1'b0, 64'd0, 1, 1'b0);
    txn(1, 12'hFFE, 1'b1, {$urandom, $urandom}, 0, 1'b0);
    txn(1, 12'hFFF, 1'b0, 64'd0, 0, 1'b0);

`ifdef BLOCK_MEM_STATS_EN
    check("rd_count", 64'(rdc0), 64'(n_rd[0]));
    check("wr_count", 64'(wrc0), 64'(n_wr[0]));
    check("rd_count_l1", 64'(rdc1), 64'(n_rd[1]));
    check("wr_count_l1", 64'(wrc1), 64'(n_wr[1]));
    force dut0.wr_count_q = 16'hFFFF;
    @(negedge clk);
    release dut0.wr_count_q;
    txn(0, 12'h050, 1'b1, 64'h5555_AAAA_5555_AAAA, 0, 1'b0);
    check("wr_count_saturates", 64'(wrc0), 64'h0000_0000_0000_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/block_mem_ctrl.md
Name: block_mem_ctrl

Overview:
- Block-granular main-memory controller sitting directly downstream of the cache controller.
- Consumes the cache's memory request (block address, cs, rw, BLOCK_SIZE-word data) and returns a one-cycle ack with a full block on reads.
- Models fixed access latency with a counter and serialises requests through a small FSM.
- Backing store is a word-addressed RAM, not reset.

Parameters:
- ADDR_WIDTH, 12, word address width
- WORD_WIDTH, 32, bits per word
- BLOCK_SIZE, 2, words per block (power of 2, >=1)
- LATENCY, 4, cycles from request acceptance to ack (must be >=1; elaboration error if 0)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  ADDR_WIDTH  word address; offset bits [clog2(BLOCK_SIZE)-1:0] ignored (block-aligned)
- mem_cs  in  1  request valid; held high by the cache until ack
- mem_rw  in  1  0 = read block, 1 = write block
- mem_wdata  in  BLOCK_SIZE*WORD_WIDTH  write block; word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- mem_ack  out  1  one-cycle completion pulse
- mem_rdata  out  BLOCK_SIZE*WORD_WIDTH  read block, valid in the ack cycle, held until the next read completes
- mem_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, counter = 0, mem_ack = 0, mem_rdata = 0, mem_busy = 0.
  - RAM contents are preserved.
  - Reset mid-transaction aborts it: no ack, and any pending write is dropped.
- FSM states: IDLE, BUSY, RESP, RELEASE.
- IDLE:
  - mem_cs high at an edge → accept the request.
  - Latch the aligned address, rw and wdata; load counter = LATENCY-1; go to BUSY.
  - Input changes after acceptance are ignored.
- BUSY:
  - Counter decrements each edge.
  - At counter == 0, perform the access:
    - Write: store all BLOCK_SIZE words at base..base+BLOCK_SIZE-1.
    - Read: register RAM[base+i] into mem_rdata word i.
  - Go to RESP.
- RESP:
  - mem_ack = 1 for exactly this cycle; go to RELEASE.
  - Latency: acceptance edge at cycle 0 → ack high in cycle LATENCY.
- RELEASE:
  - Wait for mem_cs low, then go to IDLE.
  - If cs is already low in the RESP cycle, go straight to IDLE from RELEASE on the next edge.
  - Prevents re-serving a request whose cs has not yet dropped.
- Back-to-back: the earliest new acceptance is the edge after returning to IDLE.
- mem_rdata is unchanged by writes.
- Read of a block just written returns the new data (write completes before ack).
- Address wrap: base + i is computed modulo 2^ADDR_WIDTH. It cannot overflow for aligned bases; wrap is defined for safety.
- mem_cs low in IDLE: no state change. X on unused inputs while idle must not propagate.

Optional Feature:
- Macro: BLOCK_MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0], reset to 0.
  - Each increments by 1 in the RESP cycle of a completed read or write respectively.
  - Counters saturate at 16'hFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cache_parameters supplies ADDR_WIDTH, WORD_WIDTH, BLOCK_SIZE, OFFSET_WIDTH, clog2, memory_request_t and memory_response_t. The top-level wrapper packs and unpacks to the flat ports.
- Add a state enum mem_state_t {m_idle, m_busy, m_resp, m_release} to the package.
- One natural sub-module: block_mem_ram, a BLOCK_SIZE-wide word RAM.
  - Synchronous write of a full block.
  - Registered read of a full block.
  - No reset.

Test Plan:
- Write then read: write addr 0x010, data {0xDEADBEEF, 0x12345678}, LATENCY = 4, then read 0x011 → ack exactly 4 cycles after each acceptance; read returns word0 = 0xDEADBEEF, word1 = 0x12345678.
- Sticky cs: hold cs high 3 cycles after ack → exactly one ack; no second access until cs drops and rises again.
- Input change during BUSY: accept read 0x020, change addr to 0x040 and rw to 1 during BUSY → read of 0x020 returned; no write occurs.
- Reset mid-op: assert rst_n low 2 cycles into a write to 0x030 → no ack; mem_busy = 0 and mem_rdata = 0 immediately; a subsequent read of 0x030 returns the pre-write contents.
- LATENCY = 1 back-to-back: two reads, cs dropped for one cycle between them → acks 1 cycle after each acceptance; mem_busy low for one cycle between requests.
- BLOCK_MEM_STATS_EN defined: 3 writes and 2 reads → wr_count = 3, rd_count = 2. With wr_count preloaded to 0xFFFF via force, a further write leaves it at 0xFFFF.
